// File: rtl/ether_frame_rx_if.sv
// ether_frame_rx_if: PHY receive pins and payload beat stream.
// Ports: crsdv/rxd (PHY side), axiov/axiod (payload side).
interface ether_frame_rx_if #(
    parameter int N = 4
);
    logic         crsdv;
    logic [N-1:0] rxd;
    logic         axiov;
    logic [N-1:0] axiod;

    modport master (
        output crsdv,
        output rxd,
        input  axiov,
        input  axiod
    );

    modport slave (
        input  crsdv,
        input  rxd,
        output axiov,
        output axiod
    );
endinterface

// File: rtl/ether_frame_rx.sv
// ether_frame_rx: Ethernet receive framer. Strips preamble/SFD,
// filters on destination MAC (own or broadcast), captures source
// MAC and ethertype, streams payload with the FCS withheld and
// reports a CRC-32 verdict at end of frame.
// Ports:
//   clk, rst    - receive clock, async active-high reset
//   phy         - slave side: crsdv/rxd in, axiov/axiod out
//   my_mac      - station MAC, first wire byte in [47:40]
//   src_mac     - captured source MAC, first wire byte in [47:40]
//   etype       - captured ethertype, first wire byte in [15:8]
//   hdr_valid   - high from ethertype capture until frame_done
//   frame_done  - one-cycle pulse at end of an accepted frame
//   crc_ok      - verdict, valid with frame_done
module ether_frame_rx #(
    parameter int N = 4
) (
    input  logic            clk,
    input  logic            rst,
    ether_frame_rx_if.slave phy,
    input  logic [47:0]     my_mac,
    output logic [47:0]     src_mac,
    output logic [15:0]     etype,
    output logic            hdr_valid,
    output logic            frame_done,
    output logic            crc_ok
);

    localparam int BPB       = 8 / N;
    localparam int FCS_BEATS = 32 / N;

    localparam logic [1:0]  LAST_BEAT   = 2'(BPB - 1);
    localparam logic [4:0]  LINE_FULL   = 5'(FCS_BEATS);
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRE     = 3'd1;
    localparam logic [2:0] S_DEST    = 3'd2;
    localparam logic [2:0] S_SRC     = 3'd3;
    localparam logic [2:0] S_ETYPE   = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_END     = 3'd6;
    localparam logic [2:0] S_DROP    = 3'd7;

    // PHY pins are registered once; all framing works on the
    // registered copy, which gives the extra clock of latency.
    logic [N-1:0] rxd_q;
    logic         crsdv_q;

    logic [2:0]   state;
    logic [1:0]   beat_cnt;
    logic [7-N:0] byte_sr;
    logic [2:0]   byte_idx;
    logic         seen_55;
    logic [47:0]  hdr_sr;
    logic [31:0]  crc;
    logic [4:0]   fill;
    logic [N-1:0] line_q [FCS_BEATS];

    logic [7:0]   byte_nx;
    logic [47:0]  hdr_nx;
    logic [31:0]  crc_nx;
    logic         byte_end;
    logic         dest_hit;
    logic         frame_good;
    logic         in_frame;
    logic         assembling;

    function automatic logic [31:0] crc_step(
        input logic [31:0]  c,
        input logic [N-1:0] d
    );
        logic [31:0] r;
        r = c;
        for (int i = 0; i < N; i++) begin
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
        return r;
    endfunction

    // Bytes arrive LSB first: each new beat lands at the top and
    // the older beats slide toward bit 0.
    assign byte_nx  = {rxd_q, byte_sr};
    assign hdr_nx   = {hdr_sr[39:0], byte_nx};
    assign crc_nx   = crc_step(crc, rxd_q);
    assign byte_end = (beat_cnt == LAST_BEAT);
    assign dest_hit = (hdr_nx == my_mac) || (hdr_nx == BCAST_MAC);

    assign in_frame = (state == S_DEST) || (state == S_SRC) ||
                      (state == S_ETYPE) || (state == S_PAYLOAD);

    assign assembling = crsdv_q && (in_frame || (state == S_PRE));

    // A full delay line means at least four payload+FCS bytes.
    assign frame_good = (state == S_PAYLOAD) &&
                        (crc == CRC_RESIDUE) &&
                        (beat_cnt == 2'd0) &&
                        (fill == LINE_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_q      <= '0;
            crsdv_q    <= 1'b0;
            state      <= S_IDLE;
            beat_cnt   <= 2'd0;
            byte_sr    <= '0;
            byte_idx   <= 3'd0;
            seen_55    <= 1'b0;
            hdr_sr     <= 48'h0;
            crc        <= 32'h0;
            fill       <= 5'd0;
            for (int i = 0; i < FCS_BEATS; i++) begin
                line_q[i] <= '0;
            end
            phy.axiov  <= 1'b0;
            phy.axiod  <= '0;
            src_mac    <= 48'h0;
            etype      <= 16'h0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
        end else begin
            rxd_q      <= phy.rxd;
            crsdv_q    <= phy.crsdv;
            phy.axiov  <= 1'b0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;

            if (assembling) begin
                beat_cnt <= byte_end ? 2'd0 : beat_cnt + 2'd1;
                byte_sr  <= byte_nx[7:N];
            end

            unique case (state)
                S_IDLE: begin
                    if (crsdv_q) begin
                        // The first carrier beat is already the
                        // low end of the first preamble byte.
                        state    <= S_PRE;
                        beat_cnt <= 2'd1;
                        byte_sr  <= byte_nx[7:N];
                        seen_55  <= 1'b0;
                    end
                end

                S_PRE: begin
                    if (!crsdv_q) begin
                        state <= S_IDLE;
                    end else if (byte_end) begin
                        unique case (1'b1)
                            (byte_nx == 8'h55): begin
                                seen_55 <= 1'b1;
                            end
                            (byte_nx == 8'hD5 && seen_55): begin
                                state    <= S_DEST;
                                crc      <= 32'hFFFF_FFFF;
                                byte_idx <= 3'd0;
                            end
                            default: begin
                                state <= S_DROP;
                            end
                        endcase
                    end
                end

                S_DEST, S_SRC, S_ETYPE, S_PAYLOAD: begin
                    if (!crsdv_q) begin
                        state      <= S_END;
                        frame_done <= 1'b1;
                        crc_ok     <= frame_good;
                        hdr_valid  <= 1'b0;
                    end else begin
                        crc <= crc_nx;
                        if (state == S_PAYLOAD) begin
                            line_q[0] <= rxd_q;
                            for (int i = 1; i < FCS_BEATS; i++) begin
                                line_q[i] <= line_q[i-1];
                            end
                            if (fill == LINE_FULL) begin
                                phy.axiov <= 1'b1;
                                phy.axiod <= line_q[FCS_BEATS-1];
                            end else begin
                                fill <= fill + 5'd1;
                            end
                        end else if (byte_end) begin
                            hdr_sr   <= hdr_nx;
                            byte_idx <= byte_idx + 3'd1;
                            unique case (1'b1)
                                (state == S_DEST && byte_idx == 3'd5): begin
                                    byte_idx <= 3'd0;
                                    state    <= dest_hit ? S_SRC : S_DROP;
                                end
                                (state == S_SRC && byte_idx == 3'd5): begin
                                    byte_idx <= 3'd0;
                                    src_mac  <= hdr_nx;
                                    state    <= S_ETYPE;
                                end
                                (state == S_ETYPE && byte_idx == 3'd1): begin
                                    byte_idx  <= 3'd0;
                                    etype     <= hdr_nx[15:0];
                                    hdr_valid <= 1'b1;
                                    fill      <= 5'd0;
                                    state     <= S_PAYLOAD;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end

                // Carrier re-asserting here is deliberately lost;
                // the next frame starts from IDLE.
                S_END: begin
                    state <= S_IDLE;
                end

                S_DROP: begin
                    if (!crsdv_q) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/ether_frame_rx.md
Name: ether_frame_rx

Overview:
Receive-side counterpart of the team's Ethernet transmitter. It consumes the PHY receive nibble/dibit stream (rxd, crsdv) on the Ethernet clock and strips the preamble and SFD. It filters on destination MAC (own MAC or broadcast) and captures the source MAC and ethertype. The payload goes out as an AXI-style valid/data stream with the 4-byte FCS withheld, and a CRC-32 verdict is reported at end of frame. It sits between the PHY pins and network_stack.

Parameters:
N, 4, PHY data width per clock; legal values 2 or 4; BPB = 8/N beats per byte.
FCS_BEATS, 32/N, depth of the FCS-withholding delay line (derived; do not override).

Ports:
clk  input  1  Ethernet receive clock (25/50 MHz)
rst  input  1  asynchronous active-high reset
rxd  input  N  PHY receive data; byte sent LSB-first, low beat first
crsdv  input  1  PHY carrier/data valid; high for the whole frame
my_mac  input  48  station MAC; first wire byte = bits [47:40]
axiov  output  1  payload beat valid
axiod  output  N  payload beat (same bit order as rxd)
src_mac  output  48  captured source MAC; first wire byte in [47:40]
etype  output  16  captured ethertype; first wire byte in [15:8]
hdr_valid  output  1  high from ethertype capture until frame_done
frame_done  output  1  one-cycle pulse at end of an accepted frame
crc_ok  output  1  valid with frame_done; 1 = CRC residue correct and length legal

Behaviour:
- Async reset: state=IDLE; axiov=0, axiod=0, src_mac=0, etype=0, hdr_valid=0, frame_done=0, crc_ok=0; counters, delay line and CRC cleared.
- Byte assembly: beat counter 0..BPB-1 shifts rxd into a byte register, LSB end first. It resets on every state entry from IDLE.
- States and transitions:
  - IDLE: wait for crsdv=1 -> PREAMBLE.
  - PREAMBLE: expect 0x55 bytes. Accept the SFD 0xD5 only after at least one 0x55 byte -> DEST, with CRC reg = 32'hFFFFFFFF. Any other byte -> DROP.
  - DEST: 6 bytes. Compare to my_mac or 48'hFFFFFFFFFFFF after the 6th byte. Mismatch -> DROP; match -> SRC.
  - SRC: 6 bytes into src_mac -> ETYPE.
  - ETYPE: 2 bytes into etype; hdr_valid=1 -> PAYLOAD.
  - PAYLOAD: every beat enters a FCS_BEATS-deep shift line. Once the line is full, each new beat pushes the oldest beat out with axiov=1.
  - crsdv falling in any of DEST..PAYLOAD -> END for one cycle: frame_done=1, crc_ok computed, hdr_valid cleared -> IDLE.
  - DROP: ignore input until crsdv=0 -> IDLE; no frame_done.
  - crsdv falling in PREAMBLE -> IDLE silently.
- Output latency: a payload beat appears on axiod exactly FCS_BEATS+1 clocks after it is sampled on rxd. The final FCS_BEATS beats of the frame never assert axiov.
- CRC: reflected CRC-32 (poly 0xEDB88320), N bits per cycle. Covers DEST through FCS inclusive. crc_ok=1 iff all of the following hold:
  - register equals residue 32'hDEBB20E3;
  - beat counter is 0 (whole bytes only);
  - payload+FCS length is at least 4 bytes.
  Otherwise crc_ok=0. A runt that ends in DEST/SRC/ETYPE gives frame_done with crc_ok=0.
- Consumers must discard the streamed payload when crc_ok=0. The block does not retract beats.
- crsdv re-asserting in the END cycle is ignored; the next frame begins from IDLE on the following cycle.
- Reset mid-frame aborts immediately; no frame_done.
- src_mac/etype hold until overwritten by the next frame that reaches SRC/ETYPE.

Test Plan:
- my_mac=48'h373838383838, frame 7×0x55, 0xD5, dest 37:38:38:38:38:38, src 11:22:33:44:55:66, etype F0F0, payload 00..2D (46 B), correct FCS -> 92 axiov beats (N=4) equal to payload; src_mac=48'h112233445566, etype=16'hF0F0; frame_done pulse with crc_ok=1.
- Same frame with one payload bit flipped -> identical beat count, crc_ok=0.
- Dest FF:FF:FF:FF:FF:FF -> accepted, crc_ok=1. Dest 11:11:11:11:11:11 -> no axiov, no frame_done.
- Preamble corrupted to 0x57 -> DROP, no outputs. crsdv dropped after 3 dest bytes -> frame_done with crc_ok=0.
- rst pulsed mid-payload -> all outputs 0 within the same cycle. The next good frame is received with crc_ok=1.
- N=2 build with the first frame -> 184 payload beats, latency 17 clocks, crc_ok=1.
